cache_arbiter: RTL and testbench

- Shares one Cache front-end port (addr/we/d/re/q/stall) among NUM_PORTS requesters.
- Each requester uses a simple valid/ack handshake. The arbiter sequences one access at a time into the cache and returns read data with a one-cycle ack pulse.
- Flush requests (write to the cache's flush address) pass through as ordinary writes.
- Sits between user-logic access ports and the Cache in a PyCoRAM-style design.

---
 rtl/cache_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_cache_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Shares a single Cache front-end port (addr/we/d/re/q/stall) among
// NUM_PORTS requesters. Each requester raises req_valid and holds it until
// it sees its one-cycle req_ack pulse. Exactly one access is outstanding at
// a time: the winning port's address, data and direction are latched at
// grant, driven to the Cache until it accepts them, and the arbiter then
// waits for the completion cycle before acknowledging.
//
// Flush requests are plain writes to the Cache's flush address and need no
// special handling here.
//
// Arbitration:
//   default                          round-robin, starting after last_grant
//   CACHE_ARBITER_FIXED_PRIORITY_EN  lowest-index eligible port wins
//
// Ports:
//   CLK, RST            clock; asynchronous active-low reset
//   req_valid[p]        request from port p, held until req_ack[p]
//   req_we[p]           1 = write, 0 = read
//   req_addr/req_d      packed per-port address / write data
//   req_ack             one-hot completion pulse
//   req_q               read data, valid in the ack cycle
//   grant_id            port currently or most recently served
//   busy                FSM is not IDLE
//   cache_addr/we/d/re  request to the Cache
//   cache_q/cache_stall response from the Cache
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int W_D       = 32,
    parameter int W_A       = 27,
    parameter int W_ID      = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_PORTS-1:0]     req_valid,
    input  logic [NUM_PORTS-1:0]     req_we,
    input  logic [NUM_PORTS*W_A-1:0] req_addr,
    input  logic [NUM_PORTS*W_D-1:0] req_d,
    output logic [NUM_PORTS-1:0]     req_ack,
    output logic [W_D-1:0]           req_q,
    output logic [W_ID-1:0]          grant_id,
    output logic                     busy,
    output logic [W_A-1:0]           cache_addr,
    output logic                     cache_we,
    output logic [W_D-1:0]           cache_d,
    output logic                     cache_re,
    input  logic [W_D-1:0]           cache_q,
    input  logic                     cache_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [W_ID-1:0]      last_grant;
    logic [W_A-1:0]       addr_lat;
    logic [W_D-1:0]       d_lat;
    logic                 we_lat;

    logic [NUM_PORTS-1:0] eligible;
    logic                 sel_found;
    logic [W_ID-1:0]      sel_id;
    logic [W_A-1:0]       sel_addr;
    logic [W_D-1:0]       sel_d;
    logic                 sel_we;
    logic [NUM_PORTS-1:0] ack_onehot;
    logic                 done;

    // Lowest-index set bit of elig (0 when none is set).
    function automatic logic [W_ID-1:0] pick_lowest(input logic [NUM_PORTS-1:0] elig);
        logic [W_ID-1:0] id;
        id = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (elig[i]) begin
                id = W_ID'(i);
            end
        end
        return id;
    endfunction

    // Round-robin search starting at last+1 with wrap-around: the lowest
    // eligible index above last wins, otherwise the lowest eligible overall.
    function automatic logic [W_ID-1:0] pick_round_robin(input logic [NUM_PORTS-1:0] elig,
                                                         input logic [W_ID-1:0]      last);
        logic [W_ID-1:0] hi;
        logic            hi_found;
        hi       = '0;
        hi_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (elig[i] && (W_ID'(i) > last)) begin
                hi       = W_ID'(i);
                hi_found = 1'b1;
            end
        end
        return hi_found ? hi : pick_lowest(elig);
    endfunction

    // Arbitration and selection of the winning port's request fields.
    always_comb begin
        // A port still seeing its ack this cycle must not be granted again
        // on the strength of a req_valid it has not had a chance to drop.
        eligible  = req_valid & ~req_ack;
        sel_found = |eligible;
`ifdef CACHE_ARBITER_FIXED_PRIORITY_EN
        sel_id    = pick_lowest(eligible);
`else
        sel_id    = pick_round_robin(eligible, last_grant);
`endif
        sel_addr  = '0;
        sel_d     = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (W_ID'(i) == sel_id) begin
                sel_addr = req_addr[i*W_A +: W_A];
                sel_d    = req_d[i*W_D +: W_D];
                sel_we   = req_we[i];
            end
        end
        ack_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ack_onehot[i] = (W_ID'(i) == grant_id);
        end
    end

    // Next state and Cache-side strobes.
    always_comb begin
        state_next = state;
        cache_re   = 1'b0;
        cache_we   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Held while stalled: covers Cache init, refill and flush.
                cache_we = we_lat;
                cache_re = ~we_lat;
                if (!cache_stall) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // First unstalled cycle after acceptance is the completion.
                if (!cache_stall) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cache_addr = addr_lat;
    assign cache_d    = d_lat;
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            req_ack    <= '0;
            req_q      <= '0;
            grant_id   <= '0;
            last_grant <= W_ID'(NUM_PORTS - 1);
            addr_lat   <= '0;
            d_lat      <= '0;
            we_lat     <= 1'b0;
        end else begin
            state   <= state_next;
            req_ack <= '0;
            if ((state == IDLE) && sel_found) begin
                grant_id   <= sel_id;
                last_grant <= sel_id;
                addr_lat   <= sel_addr;
                d_lat      <= sel_d;
                we_lat     <= sel_we;
            end
            if (done) begin
                if (!we_lat) begin
                    req_q <= cache_q;
                end
                req_ack <= ack_onehot;
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int NUM_PORTS = 4;
    localparam int W_D       = 32;
    localparam int W_A       = 27;
    localparam int W_ID      = 2;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic [NUM_PORTS-1:0]     req_valid;
    logic [NUM_PORTS-1:0]     req_we;
    logic [NUM_PORTS*W_A-1:0] req_addr;
    logic [NUM_PORTS*W_D-1:0] req_d;
    logic [NUM_PORTS-1:0]     req_ack;
    logic [W_D-1:0]           req_q;
    logic [W_ID-1:0]          grant_id;
    logic                     busy;
    logic [W_A-1:0]           cache_addr;
    logic                     cache_we;
    logic [W_D-1:0]           cache_d;
    logic                     cache_re;
    logic [W_D-1:0]           cache_q;
    logic                     cache_stall;

    logic [W_A-1:0] addr_arr [NUM_PORTS];
    logic [W_D-1:0] d_arr    [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_addr[i*W_A +: W_A] = addr_arr[i];
            req_d[i*W_D +: W_D]    = d_arr[i];
        end
    end

    cache_arbiter #(
        .NUM_PORTS(NUM_PORTS), .W_D(W_D), .W_A(W_A), .W_ID(W_ID)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_d(req_d),
        .req_ack(req_ack), .req_q(req_q), .grant_id(grant_id), .busy(busy),
        .cache_addr(cache_addr), .cache_we(cache_we), .cache_d(cache_d), .cache_re(cache_re),
        .cache_q(cache_q), .cache_stall(cache_stall)
    );

    always #5 CLK = ~CLK;

    // ---------------- Cache model ----------------
    logic [W_D-1:0] mem     [256];
    bit             written [256];
    logic           stall_force;
    int             miss_len;
    int             miss_left;

    assign cache_stall = stall_force | (miss_left != 0);

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            miss_left <= 0;
        end else if ((cache_re || cache_we) && !cache_stall) begin
            miss_left <= miss_len;
            if (cache_we) begin
                mem[cache_addr[7:0]]     <= cache_d;
                written[cache_addr[7:0]] <= 1'b1;
            end
        end else if (miss_left > 0) begin
            miss_left <= miss_left - 1;
        end
    end

    always_comb begin
        if (written[cache_addr[7:0]])
            cache_q = mem[cache_addr[7:0]];
        else if (cache_addr[7:0] == 8'h40)
            cache_q = 32'hDEADBEEF;
        else
            cache_q = 32'hC0DE0000 | {24'h0, cache_addr[7:0]};
    end

    // ---------------- Checking ----------------
    typedef struct {
        logic [1:0]  port;
        logic [31:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   accepts;
    int   rw_cycles;
    logic [W_A-1:0] acc_addr;
    logic [W_D-1:0] acc_d;
    logic           acc_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        check("ack_onehot", 64'($onehot(req_ack)), 64'd1);
        if (sb.size() == 0) begin
            check("ack_expected", 64'(req_ack), 64'd0);
        end else begin
            e = sb.pop_front();
            check("ack_port", 64'(req_ack), 64'(4'b0001 << e.port));
            check("req_q", 64'(req_q), 64'(e.q));
        end
    endtask

    always @(negedge CLK) begin
        if (RST && (cache_re || cache_we)) begin
            rw_cycles <= rw_cycles + 1;
            if (!cache_stall) begin
                accepts  <= accepts + 1;
                acc_addr <= cache_addr;
                acc_d    <= cache_d;
                acc_we   <= cache_we;
            end
        end
        if (req_ack != '0) sb_compare();
    end

    // Waits for any of the ports in mask to be acked; lat counts posedges.
    task automatic wait_ack(input logic [3:0] mask, input int limit, output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < limit) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if ((req_ack & mask) != 4'b0) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: no ack for mask %b within %0d cycles", mask, limit);
            lat = -1;
        end
    endtask

    typedef struct {
        logic [1:0]     port;
        logic           we;
        logic [W_A-1:0] addr;
        logic [W_D-1:0] d;
        logic [W_D-1:0] q;     // req_q expected at the ack
        int             miss;  // stall cycles after acceptance
    } vec_t;

    vec_t       vec [7];
    logic [1:0] rr_exp [6];
    int         lat;
    int         acc0;
    int         rw0;
    int         bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{2'd1, 1'b0, 27'h40, 32'h0,        32'hDEADBEEF, 0};
        vec[1] = '{2'd3, 1'b1, 27'h22, 32'h12345678, 32'hDEADBEEF, 1};
        vec[2] = '{2'd3, 1'b0, 27'h22, 32'h0,        32'h12345678, 0};
        vec[3] = '{2'd0, 1'b0, 27'h05, 32'h0,        32'hC0DE0005, 20};
        vec[4] = '{2'd2, 1'b0, 27'h80, 32'h0,        32'hC0DE0080, 3};
        vec[5] = '{2'd0, 1'b1, 27'h40, 32'hCAFEF00D, 32'hC0DE0080, 0};
        vec[6] = '{2'd1, 1'b0, 27'h40, 32'h0,        32'hCAFEF00D, 0};
`ifdef CACHE_ARBITER_FIXED_PRIORITY_EN
        rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`else
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif

        RST         = 1'b0;
        stall_force = 1'b0;
        miss_len    = 0;
        req_valid   = '0;
        req_we      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_arr[i] = '0;
            d_arr[i]    = '0;
        end
        repeat (3) @(negedge CLK);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        check("rst_req_q", 64'(req_q), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_cache_re_we", 64'({cache_re, cache_we}), 64'd0);
        check("rst_cache_addr_d", 64'(cache_addr) | 64'(cache_d), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single-port accesses: hit read, write, read-after-write, misses.
        foreach (vec[k]) begin
            miss_len = vec[k].miss;
            acc0     = accepts;
            rw0      = rw_cycles;
            req_we[vec[k].port]   = vec[k].we;
            addr_arr[vec[k].port] = vec[k].addr;
            d_arr[vec[k].port]    = vec[k].d;
            req_valid[vec[k].port] = 1'b1;
            sb.push_back('{vec[k].port, vec[k].q});
            wait_ack(4'b0001 << vec[k].port, 60, lat);
            req_valid[vec[k].port] = 1'b0;
            check("vec_latency", 64'(lat), 64'(3 + vec[k].miss));
            check("vec_accepts", 64'(accepts - acc0), 64'd1);
            check("vec_issue_cycles", 64'(rw_cycles - rw0), 64'd1);
            check("vec_cache_addr", 64'(acc_addr), 64'(vec[k].addr));
            check("vec_cache_we", 64'(acc_we), 64'(vec[k].we));
            if (vec[k].we) check("vec_cache_d", 64'(acc_d), 64'(vec[k].d));
            miss_len = 0;
            @(negedge CLK);
            check("vec_ack_pulse", 64'(req_ack), 64'd0);
        end

        // All ports requesting continuously from a fresh reset.
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_arr[p] = 27'h30 + W_A'(p);
            req_we[p]   = 1'b0;
        end
        for (int k = 0; k < 6; k++) sb.push_back('{rr_exp[k], 32'hC0DE0030 + {30'h0, rr_exp[k]}});
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wait_ack(4'hF, 20, lat);
            check("rr_grant_id", 64'(grant_id), 64'(rr_exp[k]));
            check("rr_latency", 64'(lat), 64'd3);
        end
        req_valid = 4'h0;
        @(negedge CLK);

        // Long initial stall on a write; request fields change after grant.
        stall_force = 1'b1;
        @(negedge CLK);
        acc0 = accepts;
        rw0  = rw_cycles;
        req_we[2]   = 1'b1;
        addr_arr[2] = 27'h10;
        d_arr[2]    = 32'h1;
        req_valid[2] = 1'b1;
        sb.push_back('{2'd2, 32'hC0DE0031});
        @(posedge CLK);
        #1;
        addr_arr[2] = 27'h7FFFFFF;
        d_arr[2]    = 32'hFFFFFFFF;
        bad = 0;
        repeat (300) begin
            @(negedge CLK);
            if (!(cache_we === 1'b1 && cache_re === 1'b0 && cache_addr === 27'h10 &&
                  cache_d === 32'h1 && busy === 1'b1)) bad++;
        end
        check("init_stall_hold", 64'(bad), 64'd0);
        check("init_stall_no_accept", 64'(accepts - acc0), 64'd0);
        @(posedge CLK);
        #1;
        stall_force = 1'b0;
        wait_ack(4'b0100, 20, lat);
        req_valid[2] = 1'b0;
        check("init_stall_latency", 64'(lat), 64'd2);
        check("init_stall_accepts", 64'(accepts - acc0), 64'd1);
        check("init_stall_we_cycles", 64'(rw_cycles - rw0), 64'd301);
        check("init_stall_addr", 64'(acc_addr), 64'h10);
        check("init_stall_d", 64'(acc_d), 64'h1);
        @(negedge CLK);

        // Reset while waiting on a miss; pending port 2 plus ports 0 and 3.
        miss_len    = 20;
        req_we[2]   = 1'b0;
        addr_arr[2] = 27'h50;
        req_valid[2] = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_no_strobe", 64'({cache_re, cache_we}), 64'd0);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ack", 64'(req_ack), 64'd0);
        check("async_rst_grant_id", 64'(grant_id), 64'd0);
        check("async_rst_req_q", 64'(req_q), 64'd0);
        miss_len    = 0;
        addr_arr[0] = 27'h60;
        req_we[0]   = 1'b0;
        addr_arr[3] = 27'h70;
        req_we[3]   = 1'b0;
        req_valid   = 4'b1101;
        sb.push_back('{2'd0, 32'hC0DE0060});
        sb.push_back('{2'd2, 32'hC0DE0050});
        sb.push_back('{2'd3, 32'hC0DE0070});
        @(negedge CLK);
        RST = 1'b1;
        wait_ack(4'b0001, 20, lat);
        req_valid[0] = 1'b0;
        check("post_rst_first_latency", 64'(lat), 64'd3);
        wait_ack(4'b0100, 20, lat);
        req_valid[2] = 1'b0;
        check("post_rst_second_latency", 64'(lat), 64'd3);
        wait_ack(4'b1000, 20, lat);
        req_valid[3] = 1'b0;
        check("post_rst_third_latency", 64'(lat), 64'd3);

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("idle_at_end", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
